// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant costs one idle cycle, lasts at most MAX_BURST accepted words, and
// ends early when the owner drops valid. The full flag throttles writes
// without releasing the grant; stalled cycles are counted (saturating).
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                        w_clk,
  input  logic                        w_reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        full,
  output logic                        w_en,
  output logic [DATA_W-1:0]           w_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [CNT_W-1:0]            burst_cnt,
  output logic [15:0]                 stall_cnt
);

  localparam int OW_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(MAX_BURST - 1);
  localparam logic [OW_W-1:0]  RESET_OWNER = OW_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [OW_W-1:0]        owner_q, owner_d;
  logic [OW_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [15:0]            stall_q, stall_d;
  logic [OW_W-1:0]        pick_idx;
  logic [OW_W-1:0]        cand;
  logic                   pick_found;
  logic                   owner_valid;
  logic                   accept;
  logic [DATA_W-1:0]      owner_data;
  logic [DATA_W-1:0]      data_arr [NUM_REQ];

  // Unflatten the requester data bus so the owner can be selected by index.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign owner_valid = req_valid[owner_q];
  assign owner_data  = data_arr[owner_q];

  // Round-robin search: first valid requester after the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OW_W'((int'(last_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state, handshake and write-port outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;
    req_ready = '0;
    w_en      = 1'b0;
    w_data    = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          cnt_d             = '0;
          state_d           = BURST;
        end
      end
      BURST: begin
        req_ready[owner_q] = ~full;
        accept             = owner_valid & ~full;
        if (accept) begin
          w_en   = 1'b1;
          w_data = owner_data;
          cnt_d  = cnt_q + CNT_W'(1);
        end
        // A stalled owner keeps its grant; only the stall counter moves.
        if (owner_valid && full && (stall_q != 16'hFFFF)) begin
          stall_d = stall_q + 16'd1;
        end
        if (!owner_valid || (accept && (cnt_q == LAST_CNT))) begin
          last_d  = owner_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset abandons any burst in progress.
  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= RESET_OWNER;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign grant     = grant_q;
  assign burst_cnt = cnt_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-requester word queues drive the inputs,
// a per-requester scoreboard checks every FIFO write, and each scenario
// task checks grant/burst/stall timing cycle by cycle.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);

  logic                      w_clk = 1'b0;
  logic                      w_reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      full;
  logic                      w_en;
  logic [DATA_W-1:0]         w_data;
  logic [NUM_REQ-1:0]        grant;
  logic [CNT_W-1:0]          burst_cnt;
  logic [15:0]               stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] rq    [NUM_REQ][$];
  logic [DATA_W-1:0] exp_q [NUM_REQ][$];

  logic               s_w_en;
  logic [NUM_REQ-1:0] s_grant;
  logic [CNT_W-1:0]   s_burst;
  logic [15:0]        s_stall;
  logic [NUM_REQ-1:0] s_ready;

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .w_clk(w_clk), .w_reset_n(w_reset_n), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .full(full), .w_en(w_en),
    .w_data(w_data), .grant(grant), .burst_cnt(burst_cnt), .stall_cnt(stall_cnt)
  );

  always #5 w_clk = ~w_clk;

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = rq[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  task automatic push_word(input int r, input logic [DATA_W-1:0] d);
    rq[r].push_back(d);
    exp_q[r].push_back(d);
    drive();
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i].delete();
      exp_q[i].delete();
    end
    drive();
  endtask

  // One clock cycle: sample outputs mid-cycle, score writes, clock, update requesters.
  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    logic [NUM_REQ-1:0] one_hot;
    logic [DATA_W-1:0]  expd;
    int                 o;
    #3;
    s_w_en  = w_en;
    s_grant = grant;
    s_burst = burst_cnt;
    s_stall = stall_cnt;
    s_ready = req_ready;
    hs = req_valid & req_ready;
    if (w_en) begin
      checks++;
      if (full) begin
        errors++;
        $display("FAIL w_en_while_full t=%0t w_en=%b full=%b (write must not occur)", $time, w_en, full);
      end
      o = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        one_hot = '0;
        one_hot[i] = 1'b1;
        if (grant == one_hot) o = i;
      end
      checks++;
      if (o < 0 || exp_q[o < 0 ? 0 : o].size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write t=%0t grant=%b data=%h (no word expected)", $time, grant, w_data);
      end else begin
        expd = exp_q[o].pop_front();
        if (w_data !== expd) begin
          errors++;
          $display("FAIL sb_data t=%0t req=%0d got=%h exp=%h", $time, o, w_data, expd);
        end else begin
          $display("WRITE t=%0t req=%0d data=%h", $time, o, w_data);
        end
      end
    end
    @(posedge w_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    drive();
  endtask

  task automatic do_reset();
    full = 1'b0;
    w_reset_n = 1'b0;
    flush();
    repeat (2) @(posedge w_clk);
    #1;
    w_reset_n = 1'b1;
  endtask

  task automatic check_drained(input string tag);
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL %s_drain req=%0d left=%0d exp=0", tag, i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_reset();
    full = 1'b0;
    w_reset_n = 1'b0;
    flush();
    push_word(0, 8'h11);
    push_word(2, 8'h22);
    #2;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    checks++; if (burst_cnt !== '0) begin errors++; $display("FAIL rst_burst got=%0d exp=0", burst_cnt); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
    checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL rst_w_en got=%b exp=0", w_en); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    checks++; if (w_data !== 8'h00) begin errors++; $display("FAIL rst_w_data got=%h exp=00", w_data); end
    @(posedge w_clk);
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant_held got=%b exp=0000", grant); end
    flush();
    w_reset_n = 1'b1;
  endtask

  // Single requester with 6 words: 4-word burst, bubble, then the remaining 2.
  task automatic test_single();
    logic [9:0] wen_pat;
    logic [9:0] gnt_pat;
    do_reset();
    wen_pat = 10'b0011011110;
    gnt_pat = 10'b0111011110;
    for (int n = 0; n < 6; n++) push_word(0, DATA_W'(8'hA0 + n));
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (s_w_en !== wen_pat[c]) begin errors++; $display("FAIL single_w_en c=%0d got=%b exp=%b", c, s_w_en, wen_pat[c]); end
      checks++;
      if (s_grant !== (gnt_pat[c] ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, s_grant, gnt_pat[c] ? 4'b0001 : 4'b0000);
      end
    end
    check_drained("single");
  endtask

  // Two continuous requesters alternate 4-word bursts separated by one bubble.
  task automatic test_two_req();
    logic [NUM_REQ-1:0] eg;
    int ph;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      push_word(0, DATA_W'(8'h00 + n));
      push_word(1, DATA_W'(8'h10 + n));
    end
    for (int c = 0; c < 21; c++) begin
      tick();
      ph = c % 5;
      eg = (ph == 0 || c == 20) ? 4'b0000 : (((c / 5) % 2 == 0) ? 4'b0001 : 4'b0010);
      checks++;
      if (s_grant !== eg) begin errors++; $display("FAIL two_grant c=%0d got=%b exp=%b", c, s_grant, eg); end
      checks++;
      if (s_w_en !== (eg != 4'b0000)) begin errors++; $display("FAIL two_w_en c=%0d got=%b exp=%b", c, s_w_en, eg != 4'b0000); end
      checks++;
      if (int'(s_burst) != ((eg == 4'b0000) ? 0 : ph - 1)) begin
        errors++; $display("FAIL two_burst c=%0d got=%0d exp=%0d", c, s_burst, (eg == 4'b0000) ? 0 : ph - 1);
      end
    end
    check_drained("two");
  endtask

  // req1 stalls on full for 3 cycles after 2 words, then finishes its burst.
  task automatic test_full_stall();
    int bexp [9] = '{0, 0, 1, 2, 2, 2, 2, 3, 0};
    int sexp [9] = '{0, 0, 0, 0, 1, 2, 3, 3, 3};
    logic [8:0] wexp;
    logic [8:0] gexp;
    logic [NUM_REQ-1:0] rexp;
    wexp = 9'b011000110;
    gexp = 9'b011111110;
    do_reset();
    for (int n = 0; n < 4; n++) push_word(1, DATA_W'(8'h30 + n));
    for (int c = 0; c < 9; c++) begin
      full = (c >= 3 && c <= 5);
      tick();
      rexp = (gexp[c] && !(c >= 3 && c <= 5)) ? 4'b0010 : 4'b0000;
      checks++;
      if (s_w_en !== wexp[c]) begin errors++; $display("FAIL stall_w_en c=%0d got=%b exp=%b", c, s_w_en, wexp[c]); end
      checks++;
      if (s_grant !== (gexp[c] ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL stall_grant c=%0d got=%b", c, s_grant); end
      checks++;
      if (s_ready !== rexp) begin errors++; $display("FAIL stall_ready c=%0d got=%b exp=%b", c, s_ready, rexp); end
      checks++;
      if (int'(s_burst) != bexp[c]) begin errors++; $display("FAIL stall_burst c=%0d got=%0d exp=%0d", c, s_burst, bexp[c]); end
      checks++;
      if (int'(s_stall) != sexp[c]) begin errors++; $display("FAIL stall_cnt c=%0d got=%0d exp=%0d", c, s_stall, sexp[c]); end
    end
    full = 1'b0;
    check_drained("stall");
  endtask

  // req2 drops valid after one word; req3 follows; arbitration then wraps to req0.
  task automatic test_drop_wrap();
    int gexp [14] = '{0, 4, 4, 0, 8, 8, 8, 0, 1, 1, 0, 4, 4, 0};
    int bexp [14] = '{0, 0, 1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 1, 0};
    int wexp [14] = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    do_reset();
    push_word(2, 8'h21);
    push_word(3, 8'h31);
    push_word(3, 8'h32);
    for (int c = 0; c < 14; c++) begin
      if (c == 3) begin
        push_word(0, 8'h40);
        push_word(2, 8'h42);
      end
      tick();
      checks++;
      if (int'(s_grant) != gexp[c]) begin errors++; $display("FAIL wrap_grant c=%0d got=%b exp=%0d", c, s_grant, gexp[c]); end
      checks++;
      if (int'(s_burst) != bexp[c]) begin errors++; $display("FAIL wrap_burst c=%0d got=%0d exp=%0d", c, s_burst, bexp[c]); end
      checks++;
      if (int'(s_w_en) != wexp[c]) begin errors++; $display("FAIL wrap_w_en c=%0d got=%b exp=%0d", c, s_w_en, wexp[c]); end
    end
    check_drained("wrap");
  endtask

  // Asynchronous reset in the middle of a burst, then req0 beats req2.
  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n < 6; n++) push_word(1, DATA_W'(8'h70 + n));
    repeat (3) tick();
    #2;
    checks++;
    if (w_en !== 1'b1 || w_data !== 8'h72) begin
      errors++; $display("FAIL mid_pre_w_en got=%b/%h exp=1/72", w_en, w_data);
    end
    w_reset_n = 1'b0;
    #1;
    checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL mid_w_en got=%b exp=0", w_en); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant got=%b exp=0000", grant); end
    checks++; if (burst_cnt !== '0) begin errors++; $display("FAIL mid_burst got=%0d exp=0", burst_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
    // Valid stays high during reset; any write would hit an empty scoreboard.
    for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
    tick();
    tick();
    flush();
    w_reset_n = 1'b1;
    push_word(0, 8'h50);
    push_word(2, 8'h52);
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (s_grant !== 4'b0001 || s_w_en !== 1'b1) begin
          errors++; $display("FAIL mid_regrant grant=%b w_en=%b exp=0001/1", s_grant, s_w_en);
        end
      end
      if (c == 4) begin
        checks++;
        if (s_grant !== 4'b0100) begin errors++; $display("FAIL mid_second grant=%b exp=0100", s_grant); end
      end
    end
    check_drained("mid");
  endtask

  // Long full period: stall counter saturates, no write ever leaks through.
  task automatic test_stall_sat();
    do_reset();
    push_word(0, 8'h60);
    full = 1'b1;
    for (int c = 0; c <= 70000; c++) begin
      tick();
      checks++;
      if (s_w_en !== 1'b0) begin errors++; $display("FAIL sat_w_en c=%0d got=%b exp=0", c, s_w_en); end
      if (c == 1000 || c == 65535 || c == 65536 || c == 65537 || c == 70000) begin
        checks++;
        if (int'(s_stall) != ((c - 1 > 65535) ? 65535 : c - 1)) begin
          errors++; $display("FAIL sat_stall c=%0d got=%0d exp=%0d", c, s_stall, (c - 1 > 65535) ? 65535 : c - 1);
        end
      end
    end
    full = 1'b0;
    repeat (3) tick();
    checks++;
    if (s_stall !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%0d exp=65535", s_stall); end
    check_drained("sat");
  endtask

  initial begin
    w_reset_n = 1'b0;
    full = 1'b0;
    req_valid = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_two_req();
    test_full_stall();
    test_drop_wrap();
    test_reset_mid();
    test_stall_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Shares the single write port of the async FIFO among NUM_REQ requesters in the write-clock domain. It uses round-robin arbitration with bounded bursts. It drives w_en/w_data toward the FIFO memory and write pointer controller, and it throttles on the full flag. This prevents overflow and starvation across requesters.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width per word
MAX_BURST, 4, maximum words accepted per grant (1..16)

Ports:
w_clk  input  1  write-domain clock, all logic on rising edge
w_reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester word-valid
req_data  input  NUM_REQ*DATA_W  flattened data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept strobe (combinational)
full  input  1  FIFO full flag from write pointer controller
w_en  output  1  FIFO write enable (combinational)
w_data  output  DATA_W  FIFO write data (combinational mux)
grant  output  NUM_REQ  registered one-hot owner, 0 when idle
burst_cnt  output  clog2(MAX_BURST+1)  words accepted in current grant
stall_cnt  output  16  saturating count of cycles with owner valid and full high

Behaviour:
- Reset (async, w_reset_n=0): state=IDLE, grant=0, burst_cnt=0, stall_cnt=0, last_owner=NUM_REQ-1 (req 0 has first priority). req_ready=0, w_en=0, w_data=0.
- States: IDLE, BURST.
- IDLE: if any req_valid, pick the first set bit searching from last_owner+1 upward, wrapping at NUM_REQ. Register grant one-hot, clear burst_cnt, go to BURST. No word is accepted in IDLE, so arbitration costs 1 bubble cycle. If no req_valid, stay in IDLE.
- BURST, owner g:
  - req_ready[g] = ~full. All other req_ready bits are 0.
  - Accept = req_valid[g] & ~full. On accept: w_en=1, w_data=req_data[g], burst_cnt+1.
  - When w_en=0, w_data=0.
- Release conditions, evaluated each BURST cycle:
  - (a) Accept and burst_cnt==MAX_BURST-1: the word is written, then release.
  - (b) req_valid[g]=0: release, with or without full.
  - On release: last_owner=g, grant=0, burst_cnt=0, next state IDLE.
- Full in BURST with req_valid[g]=1: no accept, burst_cnt held, grant held. stall_cnt increments, saturating at 16'hFFFF. The burst resumes on the first cycle full=0, with no extra latency.
- w_en never asserts while full=1. At most one word is written per cycle.
- Non-owner valids are ignored until the next IDLE. Fairness: each requester is served within NUM_REQ grants, worst-case wait of NUM_REQ*(MAX_BURST+1) non-full cycles.
- burst_cnt never exceeds MAX_BURST-1 while in BURST. The counter width holds MAX_BURST.
- Reset mid-burst: immediate return to the reset values above. A partially accepted burst is abandoned and no word is written during reset.
- Requesters must hold req_data stable while req_valid=1 and req_ready=0.

Test Plan:
1. Only req0 valid for 6 words, full=0 → grant=0001 at cycle 1. w_en high cycles 1–4 with data D0–D3. IDLE bubble at cycle 5. Regrant req0, D4–D5 written cycles 6–7.
2. req0 and req1 valid continuously, MAX_BURST=4 → grant sequence 0001,0010,0001… Each grant carries exactly 4 writes followed by 1 idle cycle.
3. req1 owner, full asserted after 2 writes for 3 cycles → w_en=0 and req_ready=0 for 3 cycles. burst_cnt stays 2, stall_cnt=3, then 2 more writes and release.
4. req2 drops valid after 1 word → release, burst_cnt returns to 0. req3 (pending) granted next, with wrap from 3 to 0 on the following arbitration.
5. Assert w_reset_n=0 mid-burst with full=0 and valid high → w_en/grant/burst_cnt go to 0 asynchronously. After release, req0 wins over req2 when both are valid.
6. Hold full high for 70000 cycles with owner valid → stall_cnt saturates at 65535 and w_en stays 0 throughout.
